// File: rtl/status_led.sv
// Status-to-LED sequencer: blue heartbeat while running, dimmed green on pass,
// and a sticky red blink code that serializes the debug word latched at failure.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | no status asserted, all LEDs dark
// S_RUN        | test in progress, blue square-wave heartbeat
// S_PASS       | test passed, green at PWM duty DIM
// S_FAIL_BIT   | one bit slot of the latched code, long/short red pulse
// S_FAIL_PAUSE | dark gap after bit 0 before the code repeats from bit 15
module status_led #(
  parameter int TICK_DIV = 48_000,
  parameter int HEART_MS = 250,
  parameter int SHORT_MS = 100,
  parameter int LONG_MS  = 400,
  parameter int SLOT_MS  = 600,
  parameter int PAUSE_MS = 2000,
  parameter int PWM_BITS = 8,
  parameter logic [PWM_BITS:0] DIM = (PWM_BITS+1)'(32)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_running,
  input  logic        i_passed,
  input  logic        i_error,
  input  logic [15:0] i_debug,
  output logic        o_led_r,
  output logic        o_led_g,
  output logic        o_led_b,
  output logic [15:0] o_code
);

  localparam int RUN_LEN  = 2 * HEART_MS;
  localparam int MAX_A    = (RUN_LEN > SLOT_MS) ? RUN_LEN : SLOT_MS;
  localparam int TICK_MAX = (MAX_A > PAUSE_MS) ? MAX_A : PAUSE_MS;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW       = $clog2(TICK_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL_BIT,
    S_FAIL_PAUSE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [PW-1:0]         presc;
  logic [TW-1:0]         tick_cnt;
  logic [3:0]            idx;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  tick;
  logic                  tick_last;
  logic                  in_fail;
  logic                  state_chg;
  logic                  capture;
  logic [TW-1:0]         on_len;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign in_fail   = (state == S_FAIL_BIT) || (state == S_FAIL_PAUSE);
  assign state_chg = (next_state != state);
  assign capture   = !in_fail && (next_state == S_FAIL_BIT);
  assign on_len    = o_code[idx] ? TW'(LONG_MS) : TW'(SHORT_MS);

  // Terminal count of the tick counter depends on which pattern is playing.
  always_comb begin
    tick_last = 1'b1;
    case (state)
      S_RUN:        tick_last = (tick_cnt == TW'(RUN_LEN - 1));
      S_FAIL_BIT:   tick_last = (tick_cnt == TW'(SLOT_MS - 1));
      S_FAIL_PAUSE: tick_last = (tick_cnt == TW'(PAUSE_MS - 1));
      default:      tick_last = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FAIL_BIT: begin
        if (tick && tick_last && (idx == 4'd0)) next_state = S_FAIL_PAUSE;
      end
      S_FAIL_PAUSE: begin
        if (tick && tick_last) next_state = S_FAIL_BIT;
      end
      default: begin
        if (i_error)        next_state = S_FAIL_BIT;
        else if (i_passed)  next_state = S_PASS;
        else if (i_running) next_state = S_RUN;
        else                next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      presc    <= '0;
      tick_cnt <= '0;
      idx      <= 4'd15;
      pwm_cnt  <= '0;
      o_code   <= '0;
      o_led_r  <= 1'b0;
      o_led_g  <= 1'b0;
      o_led_b  <= 1'b0;
    end else begin
      state   <= next_state;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);

      if (state_chg) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_last ? '0 : tick_cnt + TW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      // The code is captured only on entry; later debug changes are ignored.
      if (capture) begin
        o_code <= i_debug;
        idx    <= 4'd15;
      end else if ((state == S_FAIL_PAUSE) && state_chg) begin
        idx <= 4'd15;
      end else if ((state == S_FAIL_BIT) && tick && tick_last && (idx != 4'd0)) begin
        idx <= idx - 4'd1;
      end

      o_led_r <= (state == S_FAIL_BIT) && (tick_cnt < on_len);
      o_led_g <= (state == S_PASS) && ({1'b0, pwm_cnt} < DIM);
      o_led_b <= (state == S_RUN) && (tick_cnt < TW'(HEART_MS));
    end
  end

endmodule

// File: tb/tb_status_led.sv
// Bench for status_led: compares two DUT instances (DIM=3 and DIM=8) every cycle
// against a frame-arithmetic model of the LED patterns.
module tb_status_led;
  localparam int TD = 4, HM = 2, SM = 1, LM = 2, SL = 3, PM = 5, PB = 3;
  localparam int SLOT_CYC = SL * TD;
  localparam int FRAME    = 16 * SLOT_CYC + PM * TD;

  logic clk = 1'b0;
  logic rst_n = 1'b0, running = 1'b0, passed = 1'b0, error = 1'b0;
  logic [15:0] debug = '0;
  logic led_r, led_g, led_b, led_r8, led_g8, led_b8;
  logic [15:0] code, code8;

  int checks = 0;
  int failures = 0;

  status_led #(.TICK_DIV(TD), .HEART_MS(HM), .SHORT_MS(SM), .LONG_MS(LM), .SLOT_MS(SL),
               .PAUSE_MS(PM), .PWM_BITS(PB), .DIM(4'd3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
    .i_error(error), .i_debug(debug), .o_led_r(led_r), .o_led_g(led_g),
    .o_led_b(led_b), .o_code(code));

  status_led #(.TICK_DIV(TD), .HEART_MS(HM), .SHORT_MS(SM), .LONG_MS(LM), .SLOT_MS(SL),
               .PAUSE_MS(PM), .PWM_BITS(PB), .DIM(4'd8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
    .i_error(error), .i_debug(debug), .o_led_r(led_r8), .o_led_g(led_g8),
    .o_led_b(led_b8), .o_code(code8));

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 run, 2 pass, 3 fail; m_t counts edges since entry.
  int m_mode = 0, m_t = 0, m_pwm = 0, nm;
  logic [15:0] m_code = '0;
  logic e_r = 0, e_g = 0, e_b = 0, e_g8 = 0;
  wire [37:0] act_v = {led_r, led_g, led_b, code, led_r8, led_g8, led_b8, code8};
  wire [37:0] exp_v = {e_r, e_g, e_b, m_code, e_r, e_g8, e_b, m_code};

  function automatic logic fail_red(int t, logic [15:0] c);
    int p, b, tk;
    p = t % FRAME;
    if (p >= 16 * SLOT_CYC) return 1'b0;
    b  = 15 - p / SLOT_CYC;
    tk = (p % SLOT_CYC) / TD;
    return tk < (c[b] ? LM : SM);
  endfunction

  always @(posedge clk) begin
    e_r  = (m_mode == 3) && fail_red(m_t, m_code);
    e_g  = (m_mode == 2) && (m_pwm < 3);
    e_g8 = (m_mode == 2);
    e_b  = (m_mode == 1) && (((m_t / TD) % (2 * HM)) < HM);
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_pwm = 0; m_code = '0;
      e_r = 0; e_g = 0; e_b = 0; e_g8 = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 8;
      if (m_mode == 3) begin
        m_t++;
      end else begin
        nm = error ? 3 : passed ? 2 : running ? 1 : 0;
        if (nm == 3) m_code = debug;
        if (nm != m_mode) begin
          m_mode = nm;
          m_t = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  task automatic pulse_reset;
    @(negedge clk);
    rst_n = 0; running = 0; passed = 0; error = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    debug = 16'h5A3C; running = 1; passed = 1; error = 1; rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({led_r, led_g, led_b, code} !== 19'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", i, {led_r, led_g, led_b, code});
      end
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (led_r !== 1'b0 || code !== 16'h5A3C) begin
      failures++;
      $display("FAIL reset_release red=%b code=%h want red=0 code=5a3c", led_r, code);
    end
    @(negedge clk);
    checks++;
    if (led_r !== 1'b1) begin
      failures++;
      $display("FAIL red_rise got=%b want=1", led_r);
    end
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL reset_model got=%h want=%h", act_v, exp_v);
    end
  endtask

  task automatic test_run_heartbeat;
    int nb;
    pulse_reset();
    running = 1;
    nb = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL run_heartbeat cyc=%0d got=%h want=%h", i, act_v, exp_v);
      end
      if (i >= 1 && i < 17 && led_b === 1'b1) nb++;
    end
    checks++;
    if (nb != 8) begin
      failures++;
      $display("FAIL run_blue_count got=%0d want=8", nb);
    end
  endtask

  task automatic test_pass_dim;
    int ng, ng8;
    pulse_reset();
    passed = 1;
    ng = 0; ng8 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL pass_dim cyc=%0d got=%h want=%h", i, act_v, exp_v);
      end
      if (i >= 16 && i < 24) begin
        if (led_g === 1'b1) ng++;
        if (led_g8 === 1'b1) ng8++;
      end
    end
    checks++;
    if (ng != 3 || ng8 != 8) begin
      failures++;
      $display("FAIL pass_duty got=%0d/%0d want=3/8", ng, ng8);
    end
  endtask

  task automatic test_fail_code;
    logic tr [2*FRAME+20];
    int mism, s15, s14, sp;
    pulse_reset();
    debug = 16'hA001; error = 1;
    @(negedge clk);
    error = 0; debug = 16'($urandom);
    mism = 0; s15 = 0; s14 = 0; sp = 0;
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      @(negedge clk);
      debug = 16'($urandom);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL fail_code cyc=%0d got=%h want=%h", i, act_v, exp_v);
      end
      tr[i] = led_r;
    end
    for (int i = 0; i < FRAME + 20; i++) if (tr[i] !== tr[i+FRAME]) mism++;
    for (int i = 0; i < 12; i++) begin
      if (tr[i] === 1'b1) s15++;
      if (tr[i+12] === 1'b1) s14++;
    end
    for (int i = 192; i < FRAME; i++) if (tr[i] === 1'b1) sp++;
    checks++;
    if (code !== 16'hA001) begin
      failures++;
      $display("FAIL code_latch got=%h want=a001", code);
    end
    checks++;
    if (mism != 0 || s15 != 8 || s14 != 4 || sp != 0) begin
      failures++;
      $display("FAIL code_frame mism=%0d s15=%0d s14=%0d pause=%0d want 0/8/4/0", mism, s15, s14, sp);
    end
  endtask

  task automatic test_error_pass_same;
    pulse_reset();
    debug = 16'($urandom); error = 1; passed = 1;
    @(negedge clk);
    error = 0;
    for (int i = 0; i < FRAME + 30; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v || led_g !== 1'b0) begin
        failures++;
        $display("FAIL error_pass_same cyc=%0d got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_fail;
    int k;
    pulse_reset();
    debug = 16'($urandom); error = 1;
    k = 0;
    while (m_t % FRAME != 8 * SLOT_CYC + 5 && k < 2 * FRAME) begin
      @(negedge clk);
      error = 0;
      k++;
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL mid_fail_run cyc=%0d got=%h want=%h", k, act_v, exp_v);
      end
    end
    checks++;
    if (k >= 2 * FRAME) begin
      failures++;
      $display("FAIL mid_fail_timeout got=%0d want<%0d", k, 2 * FRAME);
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({led_r, led_g, led_b, code} !== 19'd0) begin
      failures++;
      $display("FAIL mid_fail_reset got=%h want=0", {led_r, led_g, led_b, code});
    end
    rst_n = 1; running = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL after_reset_run cyc=%0d got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_random;
    int len, sel;
    for (int r = 0; r < 3; r++) begin
      pulse_reset();
      for (int s = 0; s < 15; s++) begin
        sel = $urandom_range(0, 3);
        running = sel[0]; passed = sel[1];
        len = $urandom_range(1, 25);
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          checks++;
          if (act_v !== exp_v) begin
            failures++;
            $display("FAIL random_status r=%0d s=%0d got=%h want=%h", r, s, act_v, exp_v);
          end
        end
      end
      debug = 16'($urandom); error = 1;
      for (int i = 0; i < 250; i++) begin
        @(negedge clk);
        error = 1'($urandom); passed = 1'($urandom); running = 1'($urandom);
        debug = 16'($urandom);
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL random_fail r=%0d cyc=%0d got=%h want=%h", r, i, act_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_heartbeat();
    test_pass_dim();
    test_fail_code();
    test_error_pass_same();
    test_reset_mid_fail();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_led.md
# status_led

Status-to-LED sequencer sitting between a self-checking test engine (running/passed/error/debug outputs) and the `SB_RGBA_DRV` PWM inputs on the Fomu physical test bench. It converts raw status levels into human-readable patterns: blue heartbeat while running, dimmed steady green on pass, and a sticky red blink code on error that serializes the 16-bit debug word captured at the moment of failure. It replaces direct wiring of status bits to LED drivers.

## Interface
- `TICK_DIV`, 48_000, clock cycles per timing tick (1 ms at 48 MHz)
- `HEART_MS`, 250, heartbeat half-period in ticks
- `SHORT_MS`, 100, red on-time for a `0` bit, in ticks
- `LONG_MS`, 400, red on-time for a `1` bit, in ticks
- `SLOT_MS`, 600, total length of one bit slot, in ticks
- `PAUSE_MS`, 2000, dark gap after bit 0 before the code repeats, in ticks
- `PWM_BITS`, 8, width of the free-running PWM counter
- `DIM`, 32, green duty (on while pwm_cnt < DIM); `PWM_BITS+1` bits wide
- `i_clk`  input  1  system clock
- `i_rst_n`  input  1  synchronous active-low reset
- `i_running`  input  1  test in progress
- `i_passed`  input  1  test completed successfully
- `i_error`  input  1  test detected a failure
- `i_debug`  input  16  diagnostic word, captured on error
- `o_led_r`  output  1  red PWM drive
- `o_led_g`  output  1  green PWM drive
- `o_led_b`  output  1  blue PWM drive
- `o_code`  output  16  latched debug word (0 until error)

## Operation
- States: IDLE, RUN, PASS, FAIL_BIT, FAIL_PAUSE.
- Priority per edge outside FAIL: `i_error` > `i_passed` > `i_running` > none → FAIL_BIT / PASS / RUN / IDLE.
- FAIL_BIT/FAIL_PAUSE are sticky: left only by reset; `i_error` deassertion ignored.
- On edge where `i_error` is first sampled high: `o_code <= i_debug`, bit index <= 15, enter FAIL_BIT. Later `i_debug` changes ignored.
- Any state change clears the prescaler and tick counter.
- Prescaler counts 0..TICK_DIV-1; tick pulse when it wraps to 0.
- IDLE: all LEDs off.
- RUN: blue on for first HEART_MS ticks after entry, then off HEART_MS ticks, repeating (50 % square wave); red/green off.
- PASS: green = (pwm_cnt < DIM); pwm_cnt is a free-running PWM_BITS counter incremented every clock, never cleared except by reset. DIM=0 → always off; DIM ≥ 2^PWM_BITS → always on. Red/blue off.
- FAIL_BIT: slot of SLOT_MS ticks; red on for LONG_MS ticks if `o_code[idx]`=1 else SHORT_MS, then off for remainder. At slot end: idx>0 → idx-1, new slot; idx=0 → FAIL_PAUSE.
- FAIL_PAUSE: all LEDs off PAUSE_MS ticks, then idx <= 15, FAIL_BIT.
- Green and blue always off in FAIL states.
- Parameter legality (1 ≤ SHORT_MS < LONG_MS < SLOT_MS, HEART_MS ≥ 1, PAUSE_MS ≥ 1, TICK_DIV ≥ 1) is the integrator's responsibility; not checked.

## Timing
- All outputs registered. Reset (i_rst_n sampled low): state IDLE, all LEDs 0, `o_code` 0, idx 15, prescaler/tick/pwm counters 0, on that same edge.
- Reset mid-pattern aborts immediately; latched code is lost.
- Status input sampled at edge k → new state at k; LED outputs reflect new state from edge k+1 (one-cycle latency).
- Slot length exactly SLOT_MS·TICK_DIV cycles; full code frame 16·SLOT_MS·TICK_DIV + PAUSE_MS·TICK_DIV cycles.
- Simultaneous `i_error` and `i_passed`: FAIL wins. `i_passed`→`i_running` toggles restart RUN timing from zero.

## Test plan
(Bench parameters: TICK_DIV=4, HEART_MS=2, SHORT_MS=1, LONG_MS=2, SLOT_MS=3, PAUSE_MS=5, PWM_BITS=3, DIM=3.)
- Reset held 3 cycles with all status inputs high → all LEDs 0, `o_code`=0 throughout reset; one cycle after release red rises.
- `i_running`=1 only → blue high 8 cycles, low 8 cycles, repeating; red/green stay 0.
- `i_passed`=1 only → green high exactly 3 of every 8 cycles; DIM=8 rerun → green constantly 1.
- `i_debug`=16'hA001, pulse `i_error` one cycle, then change `i_debug` → `o_code`=16'hA001; slot 15 red 8 on/4 off, slot 14 red 4 on/8 off, … slot 0 red 8 on/4 off, then 20 cycles dark; pattern repeats with period 212 cycles.
- `i_error` and `i_passed` asserted same edge → FAIL pattern, green never asserts; later `i_error`=0 leaves pattern running.
- Reset asserted mid-slot 7 of FAIL → next edge all LEDs 0, `o_code`=0, subsequent `i_running` gives blue heartbeat.
